// File: rtl/bus_mux_arb_pkg.sv
// Shared types and defaults for the bus_mux_arb serial bus multiplexer/arbiter.
// Holds the FSM encoding, the "no slave" select code and an index-width helper.
package bus_mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int SEL_NONE = 0;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_NUM_SLAVES  = 3;
    localparam int DEF_SEL_W       = 2;
    localparam int DEF_TIMEOUT     = 255;
    localparam int DEF_TO_W        = 8;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_mux_arb_if.sv
// Bus bundle between serial masters, the bus_mux_arb multiplexer and serial slaves.
// Modports: master (master side), slave (slave side), mux (the multiplexer itself).
interface bus_mux_arb_if #(
    parameter int NUM_MASTERS = bus_mux_arb_pkg::DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = bus_mux_arb_pkg::DEF_NUM_SLAVES,
    parameter int SEL_W       = bus_mux_arb_pkg::DEF_SEL_W
) ();

    logic [NUM_MASTERS-1:0]       m_req;
    logic [NUM_MASTERS*SEL_W-1:0] m_slave_sel;
    logic [NUM_MASTERS-1:0]       m_master_valid;
    logic [NUM_MASTERS-1:0]       m_master_ready;
    logic [NUM_MASTERS-1:0]       m_tx_address;
    logic [NUM_MASTERS-1:0]       m_tx_data;
    logic [NUM_MASTERS-1:0]       m_write_en;
    logic [NUM_MASTERS-1:0]       m_read_en;
    logic [NUM_MASTERS-1:0]       m_rx_data;
    logic [NUM_MASTERS-1:0]       m_slave_valid;
    logic [NUM_MASTERS-1:0]       m_slave_ready;
    logic [NUM_MASTERS-1:0]       m_grant;
    logic [NUM_MASTERS-1:0]       m_error;

    logic [NUM_SLAVES-1:0]        s_master_valid;
    logic [NUM_SLAVES-1:0]        s_master_ready;
    logic [NUM_SLAVES-1:0]        s_rx_address;
    logic [NUM_SLAVES-1:0]        s_rx_data;
    logic [NUM_SLAVES-1:0]        s_write_en;
    logic [NUM_SLAVES-1:0]        s_read_en;
    logic [NUM_SLAVES-1:0]        s_tx_data;
    logic [NUM_SLAVES-1:0]        s_slave_valid;
    logic [NUM_SLAVES-1:0]        s_slave_ready;

    logic                         bus_busy;

    modport master (
        output m_req, m_slave_sel, m_master_valid, m_master_ready,
               m_tx_address, m_tx_data, m_write_en, m_read_en,
        input  m_rx_data, m_slave_valid, m_slave_ready, m_grant, m_error, bus_busy
    );

    modport slave (
        input  s_master_valid, s_master_ready, s_rx_address, s_rx_data,
               s_write_en, s_read_en,
        output s_tx_data, s_slave_valid, s_slave_ready
    );

    modport mux (
        input  m_req, m_slave_sel, m_master_valid, m_master_ready,
               m_tx_address, m_tx_data, m_write_en, m_read_en,
               s_tx_data, s_slave_valid, s_slave_ready,
        output m_rx_data, m_slave_valid, m_slave_ready, m_grant, m_error,
               s_master_valid, s_master_ready, s_rx_address, s_rx_data,
               s_write_en, s_read_en, bus_busy
    );

endinterface

// File: rtl/bus_mux_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last served index.
// The pointer moves to the picked index whenever advance is asserted.
module rr_arbiter import bus_mux_arb_pkg::*; #(
    parameter int N = DEF_NUM_MASTERS,
    localparam int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] last_q;
    logic             found;

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = int'(last_q) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

    // Reset to the last index so that index 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= IDX_W'(N - 1);
        end else if (advance && found) begin
            last_q <= idx;
        end
    end

endmodule

// File: rtl/bus_mux_arb.sv
// Parametrised serial bus multiplexer with round-robin arbitration, decode errors
// and a turnaround cycle. Optional inactivity timeout: define BUS_MUX_TIMEOUT_EN.
module bus_mux_arb import bus_mux_arb_pkg::*; #(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int TO_W        = DEF_TO_W
) (
    input  logic       clk,
    input  logic       rst,
    bus_mux_arb_if.mux bus
);

    localparam int               IDX_W   = idx_w(NUM_MASTERS);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SLAVES);

    state_t                 state_q;
    logic [IDX_W-1:0]       mst_q;
    logic [SEL_W-1:0]       slv_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] error_q;

    logic [NUM_MASTERS-1:0] arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic [SEL_W-1:0]       arb_sel;
    logic                   arb_advance;
    logic                   sel_ok;
    logic                   routed;

    assign arb_advance = (state_q == ST_IDLE) && (|bus.m_req);

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.m_req),
        .advance (arb_advance),
        .grant   (arb_grant),
        .idx     (arb_idx)
    );

    assign arb_sel = bus.m_slave_sel[arb_idx*SEL_W +: SEL_W];
    assign sel_ok  = (arb_sel != SEL_W'(SEL_NONE)) && (arb_sel <= SEL_MAX);
    assign routed  = (state_q == ST_BUSY);

`ifdef BUS_MUX_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt_q;
    logic            activity;

    assign activity = bus.m_master_valid[mst_q] | bus.s_slave_valid[slv_q] |
                      bus.s_slave_ready[slv_q];
`endif

    // A master releasing its request wins over a timeout on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mst_q      <= '0;
            slv_q      <= '0;
            grant_q    <= '0;
            error_q    <= '0;
`ifdef BUS_MUX_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            error_q <= '0;
            case (state_q)
                ST_IDLE: begin
`ifdef BUS_MUX_TIMEOUT_EN
                    idle_cnt_q <= '0;
`endif
                    if (|bus.m_req) begin
                        mst_q <= arb_idx;
                        if (sel_ok) begin
                            slv_q   <= arb_sel - SEL_W'(1);
                            grant_q <= arb_grant;
                            state_q <= ST_BUSY;
                        end else begin
                            error_q <= arb_grant;
                            state_q <= ST_RELEASE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!bus.m_req[mst_q]) begin
                        grant_q <= '0;
                        state_q <= ST_RELEASE;
                    end
`ifdef BUS_MUX_TIMEOUT_EN
                    else if (activity) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        error_q    <= grant_q;
                        grant_q    <= '0;
                        idle_cnt_q <= '0;
                        state_q    <= ST_RELEASE;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + TO_W'(1);
                    end
`endif
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Routing follows only the latched indices, so select changes mid-transaction are ignored.
    always_comb begin
        bus.s_master_valid = '0;
        bus.s_master_ready = '0;
        bus.s_rx_address   = '0;
        bus.s_rx_data      = '0;
        bus.s_write_en     = '0;
        bus.s_read_en      = '0;
        bus.m_rx_data      = '0;
        bus.m_slave_valid  = '0;
        bus.m_slave_ready  = '0;
        if (routed) begin
            bus.s_master_valid[slv_q] = bus.m_master_valid[mst_q];
            bus.s_master_ready[slv_q] = bus.m_master_ready[mst_q];
            bus.s_rx_address[slv_q]   = bus.m_tx_address[mst_q];
            bus.s_rx_data[slv_q]      = bus.m_tx_data[mst_q];
            bus.s_write_en[slv_q]     = bus.m_write_en[mst_q];
            bus.s_read_en[slv_q]      = bus.m_read_en[mst_q];
            bus.m_rx_data[mst_q]      = bus.s_tx_data[slv_q];
            bus.m_slave_valid[mst_q]  = bus.s_slave_valid[slv_q];
            bus.m_slave_ready[mst_q]  = bus.s_slave_ready[slv_q];
        end
    end

    assign bus.m_grant  = grant_q;
    assign bus.m_error  = error_q;
    assign bus.bus_busy = routed;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Self-checking bench for bus_mux_arb: directed scenarios plus randomized traffic
// against a transaction-level reference model of ownership and routing.
module tb_bus_mux_arb;

    localparam int NM      = 2;
    localparam int NS      = 3;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 255;
    localparam int TO_W    = 8;
`ifdef BUS_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    // Reference model: who owns the bus, which slave, turnaround, rotation, idle run.
    int owner;
    int oslv;
    int gap;
    int last;
    int idle_run;
    logic [NM-1:0] exp_err;

    bus_mux_arb_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_W(SEL_W)) bus ();

    bus_mux_arb #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .SEL_W       (SEL_W),
        .TIMEOUT     (TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_sel(input int m, input int v);
        bus.m_slave_sel[m*SEL_W +: SEL_W] = SEL_W'(v);
    endtask

    task automatic clear_inputs();
        bus.m_req          = '0;
        bus.m_slave_sel    = '0;
        bus.m_master_valid = '0;
        bus.m_master_ready = '0;
        bus.m_tx_address   = '0;
        bus.m_tx_data      = '0;
        bus.m_write_en     = '0;
        bus.m_read_en      = '0;
        bus.s_tx_data      = '0;
        bus.s_slave_valid  = '0;
        bus.s_slave_ready  = '0;
    endtask

    task automatic model_reset();
        owner    = -1;
        oslv     = 0;
        gap      = 0;
        last     = NM - 1;
        idle_run = 0;
        exp_err  = '0;
    endtask

    // One clock edge of the specified behaviour, evaluated on the sampled inputs.
    task automatic model_edge();
        int  w;
        int  sel;
        bit  act;
        exp_err = '0;
        if (owner >= 0) begin
            act = bus.m_master_valid[owner] || bus.s_slave_valid[oslv] || bus.s_slave_ready[oslv];
            if (!bus.m_req[owner]) begin
                owner = -1;
                gap   = 1;
            end else if (TO_EN) begin
                idle_run = act ? 0 : idle_run + 1;
                if (idle_run >= TIMEOUT) begin
                    exp_err[owner] = 1'b1;
                    owner = -1;
                    gap   = 1;
                end
            end
        end else if (gap > 0) begin
            gap = gap - 1;
        end else if (bus.m_req != '0) begin
            w = -1;
            for (int k = 1; k <= NM; k++)
                if (w < 0 && bus.m_req[(last + k) % NM]) w = (last + k) % NM;
            last = w;
            sel  = int'(bus.m_slave_sel[w*SEL_W +: SEL_W]);
            if (sel >= 1 && sel <= NS) begin
                owner    = w;
                oslv     = sel - 1;
                idle_run = 0;
            end else begin
                exp_err[w] = 1'b1;
                gap        = 1;
            end
        end
    endtask

    // Check all outputs mid-cycle, then advance model and DUT by one edge.
    task automatic cycle();
        logic [NS-1:0] e_mv, e_mr, e_ad, e_dt, e_we, e_re;
        logic [NM-1:0] e_rx, e_sv, e_sr, e_gnt;
        @(negedge clk);
        {e_mv, e_mr, e_ad, e_dt, e_we, e_re} = '0;
        {e_rx, e_sv, e_sr, e_gnt} = '0;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            e_mv[oslv]   = bus.m_master_valid[owner];
            e_mr[oslv]   = bus.m_master_ready[owner];
            e_ad[oslv]   = bus.m_tx_address[owner];
            e_dt[oslv]   = bus.m_tx_data[owner];
            e_we[oslv]   = bus.m_write_en[owner];
            e_re[oslv]   = bus.m_read_en[owner];
            e_rx[owner]  = bus.s_tx_data[oslv];
            e_sv[owner]  = bus.s_slave_valid[oslv];
            e_sr[owner]  = bus.s_slave_ready[oslv];
        end
        chk_val("grant", 32'(bus.m_grant), 32'(e_gnt));
        chk_val("error", 32'(bus.m_error), 32'(exp_err));
        chk_val("busy", 32'(bus.bus_busy), 32'(owner >= 0));
        chk_val("s_route", 32'({bus.s_master_valid, bus.s_master_ready, bus.s_rx_address,
                                bus.s_rx_data, bus.s_write_en, bus.s_read_en}),
                           32'({e_mv, e_mr, e_ad, e_dt, e_we, e_re}));
        chk_val("m_route", 32'({bus.m_rx_data, bus.m_slave_valid, bus.m_slave_ready}),
                           32'({e_rx, e_sv, e_sr}));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        chk_val("rst_grant", 32'(bus.m_grant), 32'd0);
        chk_val("rst_error", 32'(bus.m_error), 32'd0);
        chk_val("rst_busy", 32'(bus.bus_busy), 32'd0);
        chk_val("rst_route", 32'({bus.s_master_valid, bus.s_rx_data, bus.m_rx_data}), 32'd0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int errs;
        bit seen;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        clear_inputs();
        model_reset();

        // Single master to slave 2.
        do_reset();
        bus.m_req = 2'b01;
        set_sel(0, 2);
        cycle();
        chk_val("sm_grant", 32'(bus.m_grant), 32'h1);
        bus.m_master_valid[0] = 1'b1;
        bus.m_tx_data[0]      = 1'b1;
        #1;
        chk_val("sm_valid_hi", 32'(bus.s_master_valid), 32'h2);
        chk_val("sm_data_hi", 32'(bus.s_rx_data), 32'h2);
        bus.m_master_valid[0] = 1'b0;
        #1;
        chk_val("sm_valid_lo", 32'(bus.s_master_valid), 32'h0);
        cycle();

        // Contention and round-robin order.
        do_reset();
        set_sel(0, 1);
        set_sel(1, 2);
        bus.m_req = 2'b11;
        cycle();
        chk_val("cont_first", 32'(bus.m_grant), 32'h1);
        bus.m_req = 2'b10;
        cycle();
        chk_val("cont_rel", 32'(bus.m_grant), 32'h0);
        cycle();
        chk_val("cont_gap", 32'(bus.m_grant), 32'h0);
        cycle();
        chk_val("cont_second", 32'(bus.m_grant), 32'h2);
        bus.m_req = 2'b00;
        cycle();
        cycle();
        bus.m_req = 2'b11;
        cycle();
        chk_val("cont_wrap", 32'(bus.m_grant), 32'h1);
        bus.m_req = 2'b00;
        cycle();
        cycle();

        // Decode error on master 1.
        do_reset();
        set_sel(1, 0);
        bus.m_req = 2'b10;
        cycle();
        chk_val("dec_err", 32'(bus.m_error), 32'h2);
        chk_val("dec_nogrant", 32'(bus.m_grant), 32'h0);
        bus.m_req = 2'b00;
        cycle();
        chk_val("dec_err_clr", 32'(bus.m_error), 32'h0);
        set_sel(0, 1);
        bus.m_req = 2'b01;
        cycle();
        chk_val("dec_idle", 32'(bus.m_grant), 32'h1);

        // Inactivity with master 0 holding the bus.
        do_reset();
        set_sel(0, 1);
        bus.m_req = 2'b01;
        cycle();
`ifdef BUS_MUX_TIMEOUT_EN
        c = 0;
        seen = 1'b0;
        while (!seen && c < 600) begin
            c++;
            bus.m_master_valid[0] = (c == 100);
            cycle();
            seen = bus.m_error[0];
        end
        chk_val("to_cycles", 32'(c), 32'(100 + TIMEOUT));
        chk_val("to_drop", 32'(bus.m_grant), 32'h0);
`else
        errs = 0;
        for (int k = 0; k < 1000; k++) begin
            cycle();
            if (bus.m_error != '0) errs++;
        end
        chk_val("hold_grant", 32'(bus.m_grant), 32'h1);
        chk_val("hold_noerr", 32'(errs), 32'd0);
`endif

        // Return path from slave 3 and reset mid-transaction.
        do_reset();
        set_sel(1, 3);
        bus.m_req = 2'b10;
        cycle();
        chk_val("ret_grant", 32'(bus.m_grant), 32'h2);
        bus.s_tx_data         = 3'b100;
        bus.m_master_valid[1] = 1'b1;
        #1;
        chk_val("ret_rx_hi", 32'(bus.m_rx_data), 32'h2);
        bus.s_tx_data = 3'b000;
        #1;
        chk_val("ret_rx_lo", 32'(bus.m_rx_data), 32'h0);
        bus.s_tx_data = 3'b100;
        rst = 1'b0;
        #1;
        chk_val("arst_grant", 32'(bus.m_grant), 32'h0);
        chk_val("arst_busy", 32'(bus.bus_busy), 32'h0);
        chk_val("arst_route", 32'({bus.s_master_valid, bus.m_rx_data}), 32'h0);
        chk_val("arst_err", 32'(bus.m_error), 32'h0);
        do_reset();
        set_sel(0, 2);
        set_sel(1, 3);
        bus.m_req = 2'b11;
        cycle();
        chk_val("arst_regrant", 32'(bus.m_grant), 32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 7) == 0) bus.m_req[m] = ~bus.m_req[m];
                set_sel(m, int'($urandom_range(0, (1 << SEL_W) - 1)));
            end
            bus.m_master_valid = NM'($urandom);
            bus.m_master_ready = NM'($urandom);
            bus.m_tx_address   = NM'($urandom);
            bus.m_tx_data      = NM'($urandom);
            bus.m_write_en     = NM'($urandom);
            bus.m_read_en      = NM'($urandom);
            bus.s_tx_data      = NS'($urandom);
            bus.s_slave_valid  = NS'($urandom);
            bus.s_slave_ready  = NS'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
